hazard_unit: RTL

//  Pipeline hazard/forwarding unit consuming the control unit's decode-stage outputs (RegW, MemtoReg, PCS, Rd).

---
 rtl/hazard_unit_pkg.sv | 24 ++
 rtl/hazard_stage_reg.sv | 20 ++
 rtl/hazard_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
//   Shared definitions for the pipeline hazard unit.
//   FWD_* : operand-forwarding select codes driven on ForwardAE/ForwardBE.
//   fwd_sel() : chooses the forwarding source, with M taking priority over W.
package hazard_unit_pkg;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF = 2'b00;  // operand from register file
  localparam fwd_t FWD_W  = 2'b01;  // operand from ResultW
  localparam fwd_t FWD_M  = 2'b10;  // operand from ALUResultM

  // Value loaded into stage control bits for a bubble.
  localparam logic STAGE_BUBBLE = 1'b0;

  // The M-stage producer is younger than the W-stage producer.
  // On a dual match its value is therefore the architecturally correct one.
  function automatic fwd_t fwd_sel(input logic match_m, input logic match_w);
    if (match_m)      return FWD_M;
    else if (match_w) return FWD_W;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg
//   Pipeline state register with a synchronous reset and flush-to-zero.
//   Both reset and flush load all zeros. That is a bubble: no write, no load, no PC write.
//   Ports: clk, reset (sync, active-high), flush, d[W-1:0] -> q[W-1:0]
module hazard_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || flush) q <= {W{hazard_unit_pkg::STAGE_BUBBLE}};
    else                q <= d;
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Stall, flush and forwarding control for the 5-stage ARM pipeline.
//   The decoder's RegW/MemtoReg/PCS/register addresses are carried through the E/M/W stages here.
//   RegW and PCS are qualified by CondExE as an instruction leaves E.
//   Inputs : clk, reset (sync, active-high), RA1D/RA2D/WA3D, RegWD, MemtoRegD, PCSD,
//            CondExE, BranchTakenE
//   Outputs: StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE (all combinational)
//   Build option: HAZARD_FORWARD_EN
//     When defined, E-stage operands are forwarded from M/W, and only a load-use stalls.
//     When undefined, forwarding is off. Any RAW dependence on an instruction in E or M
//     stalls instead. W needs no stall because the register file writes on the falling edge.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int PC_REG = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWD,
  input  logic              MemtoRegD,
  input  logic              PCSD,
  input  logic              CondExE,
  input  logic              BranchTakenE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE
);

  localparam logic [REG_AW-1:0] PC = REG_AW'(PC_REG);
  localparam int EW = 3*REG_AW + 3;
  localparam int MW = REG_AW + 3;
  localparam int WW = REG_AW + 2;

  logic [REG_AW-1:0] ra1e, ra2e, wa3e, wa3m, wa3w;
  logic              regwe, memtorege, pcse;
  logic              regwm, memtoregm, pcsm;
  logic              regww, pcsw;
  logic              flush_e, stall, pc_pend;
  fwd_t              fwd_a, fwd_b;

  logic [EW-1:0] e_d, e_q;
  logic [MW-1:0] m_d, m_q;
  logic [WW-1:0] w_d, w_q;

  // D -> E. A stall or a taken branch loads a bubble here. StallD never freezes E.
  assign e_d = {RA1D, RA2D, WA3D, RegWD, MemtoRegD, PCSD};
  hazard_stage_reg #(.W(EW)) u_de (
    .clk(clk), .reset(reset), .flush(flush_e), .d(e_d), .q(e_q)
  );
  assign {ra1e, ra2e, wa3e, regwe, memtorege, pcse} = e_q;

  // E -> M. The condition is only known in E, so the write enables are qualified here.
  assign m_d = {wa3e, regwe & CondExE, memtorege, pcse & CondExE};
  hazard_stage_reg #(.W(MW)) u_em (
    .clk(clk), .reset(reset), .flush(1'b0), .d(m_d), .q(m_q)
  );
  assign {wa3m, regwm, memtoregm, pcsm} = m_q;

  // M -> W
  assign w_d = {wa3m, regwm, pcsm};
  hazard_stage_reg #(.W(WW)) u_mw (
    .clk(clk), .reset(reset), .flush(1'b0), .d(w_d), .q(w_q)
  );
  assign {wa3w, regww, pcsw} = w_q;

  // R15 reads come from the PC path, so a read of R15 never hazards.
  logic hit1e, hit2e;
  assign hit1e = (RA1D != PC) && (RA1D == wa3e);
  assign hit2e = (RA2D != PC) && (RA2D == wa3e);

`ifdef HAZARD_FORWARD_EN
  logic match_1e_m, match_2e_m, match_1e_w, match_2e_w;
  logic unused_bits;

  assign match_1e_m = (ra1e == wa3m) && regwm && (ra1e != PC);
  assign match_2e_m = (ra2e == wa3m) && regwm && (ra2e != PC);
  assign match_1e_w = (ra1e == wa3w) && regww && (ra1e != PC);
  assign match_2e_w = (ra2e == wa3w) && regww && (ra2e != PC);

  assign fwd_a = fwd_sel(match_1e_m, match_1e_w);
  assign fwd_b = fwd_sel(match_2e_m, match_2e_w);

  // Load data is only available from W. A consumer directly behind a load needs one bubble.
  assign stall = memtorege && regwe && (hit1e || hit2e);

  assign unused_bits = memtoregm;
`else
  logic hit1m, hit2m;
  logic unused_bits;

  assign hit1m = (RA1D != PC) && (RA1D == wa3m);
  assign hit2m = (RA2D != PC) && (RA2D == wa3m);

  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  // E uses the unqualified RegW because its condition is still unresolved.
  assign stall = (regwe && (hit1e || hit2e)) || (regwm && (hit1m || hit2m));

  assign unused_bits = ^{ra1e, ra2e, memtorege, memtoregm, wa3w, regww};
`endif

  // PCSE is taken unqualified: a PC write in E may still pass its condition.
  assign pc_pend = PCSD || pcse || pcsm;
  assign flush_e = stall || BranchTakenE;

  // Outputs are forced quiet during reset so that stale stage state has no effect.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      StallF    = stall || pc_pend;
      StallD    = stall;
      FlushD    = pc_pend || pcsw || BranchTakenE;
      FlushE    = flush_e;
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
    end
  end

endmodule
